// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and sizing helpers for the seven-segment scan driver.
package seven_seg_pkg;

    typedef enum logic [2:0] {
        SEG_IDX_A = 3'd0,
        SEG_IDX_B = 3'd1,
        SEG_IDX_C = 3'd2,
        SEG_IDX_D = 3'd3,
        SEG_IDX_E = 3'd4,
        SEG_IDX_F = 3'd5,
        SEG_IDX_G = 3'd6
    } seg_idx_e;

    // Active-high patterns, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Datapath-side and pin-side bundle of the seven-segment scan driver.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en_i;
    logic                    load_i;
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_o;

    modport master (
        output en_i, load_i, value_i, dp_i,
        input  seg_o, dp_o, an_o, frame_o
    );

    modport slave (
        input  en_i, load_i, value_i, dp_i,
        output seg_o, dp_o, an_o, frame_o
    );

endinterface

// File: rtl/seven_seg_hex_decoder.sv
// Combinational 4-bit code to active-high seven-segment pattern.
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_en_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = hex_en_i ? SEG_A : SEG_BLANK;
            4'hB: seg_o = hex_en_i ? SEG_B : SEG_BLANK;
            4'hC: seg_o = hex_en_i ? SEG_C : SEG_BLANK;
            4'hD: seg_o = hex_en_i ? SEG_D : SEG_BLANK;
            4'hE: seg_o = hex_en_i ? SEG_E : SEG_BLANK;
            4'hF: seg_o = hex_en_i ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with tear-free frame updates.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int COMMON_ANODE  = 0,
    parameter int HEX_EN        = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    seven_seg_scan_driver_if.slave  bus
);

    localparam int PW = clog2_min1(SCAN_DIV);
    localparam int IW = clog2_min1(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          POL        = (COMMON_ANODE != 0);
    localparam logic          HEX_ON     = (HEX_EN != 0);
    localparam logic          BLANK_ON   = (BLANK_LEADING != 0);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [VW-1:0]         shad_val_q, shad_val_d;
    logic [NUM_DIGITS-1:0] shad_dp_q, shad_dp_d;
    logic [VW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  tc;
    logic                  boundary;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_upper_zero;
    logic [NUM_DIGITS-1:0] an_hot;
    logic                  blank;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_act;

    always_comb begin
        sel_nib        = '0;
        sel_dp         = 1'b0;
        sel_upper_zero = 1'b0;
        an_hot         = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_nib        = disp_val_q[4*k +: 4];
                sel_dp         = disp_dp_q[k];
                sel_upper_zero = ((disp_val_q >> (4 * k)) == '0);
                an_hot[k]      = 1'b1;
            end
        end
    end

    seven_seg_hex_decoder u_dec (
        .code_i   (sel_nib),
        .hex_en_i (HEX_ON),
        .seg_o    (dec_seg)
    );

    assign blank   = BLANK_ON && (idx_q != '0) && sel_upper_zero;
    assign seg_act = blank ? SEG_BLANK : dec_seg;

    assign tc       = (presc_q == PRESC_LAST);
    assign boundary = bus.en_i && tc && (idx_q == IDX_LAST);

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        frame_d = boundary;
        if (!bus.en_i) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (tc) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // A load landing on the boundary bypasses the shadow so it is never lost.
    always_comb begin
        shad_val_d = shad_val_q;
        shad_dp_d  = shad_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
            if (bus.load_i) begin
                disp_val_d = bus.value_i;
                disp_dp_d  = bus.dp_i;
            end else if (pend_q) begin
                disp_val_d = shad_val_q;
                disp_dp_d  = shad_dp_q;
            end
        end else if (bus.load_i) begin
            shad_val_d = bus.value_i;
            shad_dp_d  = bus.dp_i;
            pend_d     = 1'b1;
        end
    end

    always_comb begin
        seg_d = {7{POL}};
        dpo_d = POL;
        an_d  = {NUM_DIGITS{POL}};
        if (bus.en_i) begin
            seg_d = seg_act ^ {7{POL}};
            dpo_d = sel_dp ^ POL;
            an_d  = an_hot ^ {NUM_DIGITS{POL}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            shad_val_q <= '0;
            shad_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= {7{POL}};
            dpo_q      <= POL;
            an_q       <= {NUM_DIGITS{POL}};
            frame_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            shad_val_q <= shad_val_d;
            shad_dp_q  <= shad_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dpo_q      <= dpo_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dpo_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: three driver configurations against a time-arithmetic display model.
module tb_seven_seg_scan_driver;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fr;
    } out_t;

    typedef out_t [2:0] exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_prev = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int ND  [3] = '{4, 4, 3};
    int SD  [3] = '{4, 4, 1};
    bit CA  [3] = '{1'b0, 1'b1, 1'b0};
    bit HEX [3] = '{1'b1, 1'b0, 1'b1};
    bit BL  [3] = '{1'b1, 1'b0, 1'b1};

    logic [6:0] segtab [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int unsigned cyc    [3];
    logic [15:0] disp_v [3];
    logic [15:0] sh_v   [3];
    logic [3:0]  disp_p [3];
    logic [3:0]  sh_p   [3];
    bit          pend   [3];

    exp_t q [$];

    seven_seg_scan_driver_if #(.NUM_DIGITS(4)) if1 ();
    seven_seg_scan_driver_if #(.NUM_DIGITS(4)) if2 ();
    seven_seg_scan_driver_if #(.NUM_DIGITS(3)) if3 ();

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(0),
        .HEX_EN(1), .BLANK_LEADING(1)
    ) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(1),
        .HEX_EN(0), .BLANK_LEADING(0)
    ) u2 (.clk_i(clk), .rst_i(rst), .bus(if2));

    seven_seg_scan_driver #(
        .NUM_DIGITS(3), .SCAN_DIV(1), .COMMON_ANODE(0),
        .HEX_EN(1), .BLANK_LEADING(1)
    ) u3 (.clk_i(clk), .rst_i(rst), .bus(if3));

    always #5 clk = ~clk;

    function automatic logic [3:0] an_mask(input int d);
        return 4'((1 << ND[d]) - 1);
    endfunction

    function automatic out_t inactive_of(input int d);
        out_t o;
        o = '0;
        if (CA[d]) begin
            o.seg = 7'h7F;
            o.dp  = 1'b1;
            o.an  = an_mask(d);
        end
        return o;
    endfunction

    function automatic out_t model_step(input int d, input logic r, input logic e,
                                        input logic l, input logic [15:0] v,
                                        input logic [3:0] p);
        out_t o;
        int n, fl, dig;
        logic [15:0] vm;
        logic [3:0] pm, nib;
        bit blank;
        n  = ND[d];
        fl = SD[d] * n;
        vm = v & 16'((17'h1 << (4 * n)) - 1);
        pm = p & an_mask(d);
        o  = inactive_of(d);
        if (r) begin
            cyc[d] = 0; disp_v[d] = '0; disp_p[d] = '0;
            sh_v[d] = '0; sh_p[d] = '0; pend[d] = 1'b0;
        end else if (!e) begin
            cyc[d] = 0;
            if (l) begin sh_v[d] = vm; sh_p[d] = pm; pend[d] = 1'b1; end
        end else begin
            dig   = int'(cyc[d] / SD[d]) % n;
            nib   = disp_v[d][4*dig +: 4];
            blank = BL[d] && dig > 0 && ((disp_v[d] >> (4 * dig)) == 16'h0);
            o.seg = (blank || (!HEX[d] && nib > 4'd9)) ? 7'h00 : segtab[nib];
            o.dp  = disp_p[d][dig];
            o.an  = 4'(1 << dig);
            o.fr  = (int'(cyc[d]) % fl) == fl - 1;
            if (CA[d]) begin
                o.seg = ~o.seg;
                o.dp  = ~o.dp;
                o.an  = o.an ^ an_mask(d);
            end
            if (o.fr) begin
                if (l) begin disp_v[d] = vm; disp_p[d] = pm; end
                else if (pend[d]) begin disp_v[d] = sh_v[d]; disp_p[d] = sh_p[d]; end
                pend[d] = 1'b0;
            end else if (l) begin
                sh_v[d] = vm; sh_p[d] = pm; pend[d] = 1'b1;
            end
            cyc[d]++;
        end
        return o;
    endfunction

    function automatic out_t act_of(input int d);
        out_t o;
        o = '0;
        case (d)
            0: o = {if1.seg_o, if1.dp_o, if1.an_o, if1.frame_o};
            1: o = {if2.seg_o, if2.dp_o, if2.an_o, if2.frame_o};
            default: o = {if3.seg_o, if3.dp_o, 1'b0, if3.an_o, if3.frame_o};
        endcase
        return o;
    endfunction

    task automatic check(input string nm, input int d, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got seg=%h dp=%b an=%b frame=%b, want seg=%h dp=%b an=%b frame=%b",
                     nm, d, $time, act.seg, act.dp, act.an, act.fr,
                     exp.seg, exp.dp, exp.an, exp.fr);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l,
                         input logic [15:0] v, input logic [3:0] p);
        exp_t x;
        @(posedge clk);
        #2;
        rst = r;
        if1.en_i = e; if1.load_i = l; if1.value_i = v;       if1.dp_i = p;
        if2.en_i = e; if2.load_i = l; if2.value_i = v;       if2.dp_i = p;
        if3.en_i = e; if3.load_i = l; if3.value_i = v[11:0]; if3.dp_i = p[2:0];
        for (int d = 0; d < 3; d++) x[d] = model_step(d, r, e, l, v, p);
        q.push_back(x);
        if (r && !rst_prev) begin
            #1;
            for (int d = 0; d < 3; d++) check("async_reset", d, act_of(d), inactive_of(d));
        end
        rst_prev = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] p);
        drive(1'b0, 1'b1, 1'b1, v, p);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 64 && (int'(cyc[0]) % 16) != ph; i++) idle(1);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                for (int d = 0; d < 3; d++) check("scan", d, act_of(d), x[d]);
            end
        end
    end

    initial begin : stim
        logic [15:0] v;
        if1.en_i = 0; if1.load_i = 0; if1.value_i = '0; if1.dp_i = '0;
        if2.en_i = 0; if2.load_i = 0; if2.value_i = '0; if2.dp_i = '0;
        if3.en_i = 0; if3.load_i = 0; if3.value_i = '0; if3.dp_i = '0;
        for (int d = 0; d < 3; d++) void'(model_step(d, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0));
        repeat (3) drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 4'h0);
        idle(40);
        wait_phase(5);
        load(16'h1111, 4'h0);
        idle(40);
        wait_phase(15);
        load(16'h5678, 4'b1010);
        idle(20);
        wait_phase(2);
        load(16'h2222, 4'h1);
        idle(3);
        load(16'h3333, 4'h2);
        idle(36);
        load(16'h0050, 4'b0100);
        idle(36);
        load(16'h0000, 4'b0100);
        idle(36);
        load(16'h00A0, 4'h0);
        idle(36);
        load(16'h0008, 4'h0);
        idle(36);
        load(16'h4321, 4'h0);
        idle(20);
        for (int i = 0; i < 64 && ((int'(cyc[0]) / 4) % 4) != 2; i++) idle(1);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(20);
        load(16'h9876, 4'h3);
        idle(24);
        wait_phase(6);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(24);
        for (int i = 0; i < 2500; i++) begin
            v = '0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) != 0,
                  $urandom_range(0, 7) == 0, v, 4'($urandom));
        end
        idle(2);
        @(posedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
